// File: rtl/dctq_rle_pkg.sv
// Shared constants, widths and FSM encoding for the DCT-coefficient run-length coder.
// The optional DC-differential mode is selected with DCTQ_RLE_DCDIFF_EN.
package dctq_rle_pkg;

  localparam int BLK_SIZE = 64;
  localparam int ADDR_W   = 6;
  localparam int COEF_W   = 9;
  localparam int RUN_W    = 4;
  localparam int LEVEL_W  = 10;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    ZRL  = 3'd2,
    EMIT = 3'd3,
    EOB  = 3'd4
  } state_t;

endpackage

// File: rtl/dctq_rle_if.sv
// Coefficient input and token output bundle of dctq_rle.
// master = upstream source plus token sink; slave = the coder.
interface dctq_rle_if;
  import dctq_rle_pkg::*;

  logic signed [COEF_W-1:0]  dctq;
  logic                      dctq_valid;
  logic        [ADDR_W-1:0]  addr;
  logic                      hold;
  logic        [RUN_W-1:0]   rl_run;
  logic signed [LEVEL_W-1:0] rl_level;
  logic                      rl_eob;
  logic                      rl_valid;
  logic                      rl_ready;

  modport master (
    output dctq, dctq_valid, addr, rl_ready,
    input  hold, rl_run, rl_level, rl_eob, rl_valid
  );

  modport slave (
    input  dctq, dctq_valid, addr, rl_ready,
    output hold, rl_run, rl_level, rl_eob, rl_valid
  );

endinterface

// File: rtl/dctq_zigzag_rom.sv
// Combinational map from zigzag scan index to raster address (row*8+col) of an 8x8 block.
module dctq_zigzag_rom
  import dctq_rle_pkg::*;
(
  input  logic [ADDR_W-1:0] zz_idx,
  output logic [ADDR_W-1:0] raster_addr
);

  localparam logic [ADDR_W-1:0] ZZ_TAB [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  assign raster_addr = ZZ_TAB[zz_idx];

endmodule

// File: rtl/dctq_rle.sv
// Ping-pong buffered zigzag run-length coder for 8x8 quantized DCT blocks.
// Define DCTQ_RLE_DCDIFF_EN to code the DC token as the difference from the previous block's DC.
module dctq_rle
  import dctq_rle_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  dctq_rle_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_SIZE - 1);
  localparam logic [CNT_W-1:0]  ZRL_LEN  = CNT_W'(16);

  logic signed [COEF_W-1:0]  mem [2*BLK_SIZE];
  logic signed [COEF_W-1:0]  rd_data_p1;
  logic        [ADDR_W-1:0]  rd_idx;
  logic        [ADDR_W-1:0]  rd_addr;
  logic        [ADDR_W-1:0]  cur_idx;
  logic                      wsel;
  logic                      rsel;
  logic        [1:0]         full;
  logic                      hold_q;
  state_t                    state;
  logic        [CNT_W-1:0]   run;
  logic signed [LEVEL_W-1:0] pend_level;
  logic                      last;
  logic        [RUN_W-1:0]   rl_run_q;
  logic signed [LEVEL_W-1:0] rl_level_q;
  logic                      rl_eob_q;
  logic                      rl_valid_q;
  logic                      wr_en;
  logic                      fill;
  logic                      hs;
  logic                      rel;
`ifdef DCTQ_RLE_DCDIFF_EN
  logic signed [COEF_W-1:0]  prev_dc;
`endif

  function automatic logic signed [LEVEL_W-1:0] sext_level(input logic signed [COEF_W-1:0] v);
    return {{(LEVEL_W-COEF_W){v[COEF_W-1]}}, v};
  endfunction

  assign wr_en = bus.dctq_valid && !hold_q;
  assign fill  = wr_en && (bus.addr == LAST_IDX);
  assign hs    = rl_valid_q && bus.rl_ready;
  assign rel   = hs && ((state == EOB) || ((state == EMIT) && last));

  // rd_data_p1 always holds the coefficient at cur_idx while scanning; SCAN prefetches the next one.
  always_comb begin
    rd_idx = cur_idx;
    if (state == IDLE)
      rd_idx = '0;
    else if (state == SCAN)
      rd_idx = cur_idx + ADDR_W'(1);
  end

  dctq_zigzag_rom u_zigzag (
    .zz_idx      (rd_idx),
    .raster_addr (rd_addr)
  );

  // Stage p0 -> p1: bank write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wsel, bus.addr}] <= bus.dctq;
    rd_data_p1 <= mem[{rsel, rd_addr}];
  end

  // A release in the same cycle as a fill frees the other bank, so it overrides raising hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wsel   <= 1'b0;
      rsel   <= 1'b0;
      full   <= '0;
      hold_q <= 1'b0;
    end else begin
      if (fill) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (rel) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
      if (rel)
        hold_q <= 1'b0;
      else if (fill && full[~wsel])
        hold_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_idx    <= '0;
      run        <= '0;
      pend_level <= '0;
      last       <= 1'b0;
      rl_run_q   <= '0;
      rl_level_q <= '0;
      rl_eob_q   <= 1'b0;
      rl_valid_q <= 1'b0;
`ifdef DCTQ_RLE_DCDIFF_EN
      prev_dc    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cur_idx <= '0;
          run     <= '0;
          if (full[rsel])
            state <= SCAN;
        end
        SCAN: begin
          cur_idx <= cur_idx + ADDR_W'(1);
          last    <= (cur_idx == LAST_IDX);
          if (cur_idx == '0) begin
            rl_run_q   <= '0;
`ifdef DCTQ_RLE_DCDIFF_EN
            rl_level_q <= sext_level(rd_data_p1) - sext_level(prev_dc);
`else
            rl_level_q <= sext_level(rd_data_p1);
`endif
            rl_eob_q   <= 1'b0;
            rl_valid_q <= 1'b1;
            state      <= EMIT;
          end else if (rd_data_p1 == '0) begin
            if (cur_idx == LAST_IDX) begin
              rl_run_q   <= '0;
              rl_level_q <= '0;
              rl_eob_q   <= 1'b1;
              rl_valid_q <= 1'b1;
              run        <= '0;
              state      <= EOB;
            end else begin
              run <= run + CNT_W'(1);
            end
          end else if (run[CNT_W-1:RUN_W] != '0) begin
            rl_run_q   <= '1;
            rl_level_q <= '0;
            rl_eob_q   <= 1'b0;
            rl_valid_q <= 1'b1;
            run        <= run - ZRL_LEN;
            pend_level <= sext_level(rd_data_p1);
            state      <= ZRL;
          end else begin
            rl_run_q   <= run[RUN_W-1:0];
            rl_level_q <= sext_level(rd_data_p1);
            rl_eob_q   <= 1'b0;
            rl_valid_q <= 1'b1;
            run        <= '0;
            state      <= EMIT;
          end
        end
        ZRL: begin
          if (hs) begin
            if (run[CNT_W-1:RUN_W] != '0) begin
              run <= run - ZRL_LEN;
            end else begin
              rl_run_q   <= run[RUN_W-1:0];
              rl_level_q <= pend_level;
              run        <= '0;
              state      <= EMIT;
            end
          end
        end
        EMIT: begin
          if (hs) begin
            rl_valid_q <= 1'b0;
            state      <= last ? IDLE : SCAN;
`ifdef DCTQ_RLE_DCDIFF_EN
            // Only the DC token leaves cur_idx at 1; level is dc - prev_dc, so adding it back recovers dc.
            if (cur_idx == ADDR_W'(1))
              prev_dc <= prev_dc + rl_level_q[COEF_W-1:0];
`endif
          end
        end
        EOB: begin
          if (hs) begin
            rl_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hold     = hold_q;
  assign bus.rl_run   = rl_run_q;
  assign bus.rl_level = rl_level_q;
  assign bus.rl_eob   = rl_eob_q;
  assign bus.rl_valid = rl_valid_q;

endmodule

// File: tb/tb_dctq_rle.sv
// Directed bench for dctq_rle: token streams for hand-built blocks, back-pressure, hold and reset.
module tb_dctq_rle;
  import dctq_rle_pkg::*;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   prev_dc_m = 0;
  int   lvl_a;
  logic signed [COEF_W-1:0] blk [BLK_SIZE];

  dctq_rle_if bus ();

  dctq_rle dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_dc(input int dc);
    int lvl;
`ifdef DCTQ_RLE_DCDIFF_EN
    lvl = dc - prev_dc_m;
`else
    lvl = dc;
`endif
    prev_dc_m = dc;
    return lvl;
  endfunction

  task automatic clear_blk();
    for (int i = 0; i < BLK_SIZE; i++) blk[i] = '0;
  endtask

  task automatic write_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      bus.dctq_valid = 1'b1;
      bus.addr       = ADDR_W'(a);
      bus.dctq       = blk[a];
      tick();
    end
    bus.dctq_valid = 1'b0;
  endtask

  task automatic expect_tok(input string tag, input int r, input int l, input int e);
    logic [RUN_W-1:0]          gr;
    logic signed [LEVEL_W-1:0] gl;
    logic                      ge;
    bit                        ok;
    ok = 1'b0;
    gr = '0;
    gl = '0;
    ge = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.rl_valid === 1'b1) begin
        gr = bus.rl_run;
        gl = bus.rl_level;
        ge = bus.rl_eob;
        ok = 1'b1;
      end
      tick();
    end
    total++;
    assert (ok) else begin
      bad++;
      $error("FAIL %s no token within 300 cycles observed=0 expected=1", tag);
    end
    if (ok) begin
      check({tag, ".run"}, gr, r);
      check({tag, ".level"}, gl, l);
      check({tag, ".eob"}, ge, e);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (bus.rl_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    check(tag, seen, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.dctq_valid = 1'b0;
    bus.addr       = '0;
    bus.dctq       = '0;
    bus.rl_ready   = 1'b1;
    repeat (3) tick();
    check("rst.hold", bus.hold, 0);
    check("rst.valid", bus.rl_valid, 0);
    check("rst.run", bus.rl_run, 0);
    check("rst.level", bus.rl_level, 0);
    check("rst.eob", bus.rl_eob, 0);
    reset_n = 1'b1;
    tick();

    // DC only, plus first-token latency after the addr=63 write
    clear_blk();
    blk[0] = 9'sd25;
    write_range(0, 63);
    check("t1.lat1", bus.rl_valid, 0);
    tick();
    check("t1.lat2", bus.rl_valid, 0);
    tick();
    check("t1.lat3", bus.rl_valid, 1);
    expect_tok("t1.dc", 0, exp_dc(25), 0);
    expect_tok("t1.eob", 0, 0, 1);
    expect_quiet("t1.quiet", 10);

    clear_blk();
    blk[1] = -9'sd3;
    blk[8] = 9'sd5;
    write_range(0, 63);
    expect_tok("t2.dc", 0, exp_dc(0), 0);
    expect_tok("t2.ac1", 0, -3, 0);
    expect_tok("t2.ac2", 0, 5, 0);
    expect_tok("t2.eob", 0, 0, 1);

    // zigzag index 20 is raster 40
    clear_blk();
    blk[40] = 9'sd7;
    write_range(0, 63);
    expect_tok("t3.dc", 0, exp_dc(0), 0);
    expect_tok("t3.zrl", 15, 0, 0);
    expect_tok("t3.ac", 3, 7, 0);
    expect_tok("t3.eob", 0, 0, 1);

    clear_blk();
    blk[63] = 9'sd4;
    write_range(0, 63);
    expect_tok("t4.dc", 0, exp_dc(0), 0);
    expect_tok("t4.zrl1", 15, 0, 0);
    expect_tok("t4.zrl2", 15, 0, 0);
    expect_tok("t4.zrl3", 15, 0, 0);
    expect_tok("t4.ac", 14, 4, 0);
    expect_quiet("t4.no_eob", 20);

    // back-pressure: two full banks raise hold, third block is dropped
    bus.rl_ready = 1'b0;
    clear_blk();
    blk[0] = 9'sd9;
    write_range(0, 63);
    lvl_a = exp_dc(9);
    repeat (5) tick();
    check("t5.stall.valid", bus.rl_valid, 1);
    check("t5.stall.level", bus.rl_level, lvl_a);
    clear_blk();
    blk[0] = -9'sd7;
    write_range(0, 62);
    check("t5.hold_before", bus.hold, 0);
    write_range(63, 63);
    check("t5.hold_after", bus.hold, 1);
    check("t5.stable.run", bus.rl_run, 0);
    check("t5.stable.level", bus.rl_level, lvl_a);
    check("t5.stable.eob", bus.rl_eob, 0);
    for (int i = 0; i < BLK_SIZE; i++) blk[i] = 9'sd50;
    write_range(0, 63);
    check("t5.hold_kept", bus.hold, 1);
    bus.rl_ready = 1'b1;
    expect_tok("t5.a.dc", 0, lvl_a, 0);
    check("t5.hold_mid", bus.hold, 1);
    expect_tok("t5.a.eob", 0, 0, 1);
    check("t5.hold_released", bus.hold, 0);
    expect_tok("t5.b.dc", 0, exp_dc(-7), 0);
    expect_tok("t5.b.eob", 0, 0, 1);
    expect_quiet("t5.third_dropped", 30);

    // DC differential across consecutive blocks, from a fresh reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    prev_dc_m = 0;
    tick();
    clear_blk();
    blk[0] = 9'sd25;
    write_range(0, 63);
    expect_tok("t6.dc25", 0, exp_dc(25), 0);
    expect_tok("t6.eob1", 0, 0, 1);
    clear_blk();
    blk[0] = 9'sd20;
    write_range(0, 63);
`ifdef DCTQ_RLE_DCDIFF_EN
    expect_tok("t6.dc20", 0, -5, 0);
`else
    expect_tok("t6.dc20", 0, 20, 0);
`endif
    expect_tok("t6.eob2", 0, 0, 1);

    // reset while a token is pending and a second block is half written
    bus.rl_ready = 1'b0;
    clear_blk();
    blk[0] = 9'sd5;
    write_range(0, 63);
    repeat (4) tick();
    check("t7.pending", bus.rl_valid, 1);
    write_range(0, 30);
    reset_n = 1'b0;
    #1;
    check("t7.async.valid", bus.rl_valid, 0);
    check("t7.async.hold", bus.hold, 0);
    tick();
    reset_n = 1'b1;
    bus.rl_ready = 1'b1;
    expect_quiet("t7.no_tokens", 40);
    check("t7.hold", bus.hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dctq_rle.md
DCTQ_RLE -- requirements
Module: dctq_rle

Interface
REQ-001 SHALL have ports: clk, in, 1, single clock for all state.
REQ-002 SHALL have ports: reset_n, in, 1, reset, asynchronous and active-low.
REQ-003 SHALL have ports: dctq, in, 9, signed quantized coefficient.
REQ-004 SHALL have ports: dctq_valid, in, 1, dctq and addr valid this cycle.
REQ-005 SHALL have ports: addr, in, 6, raster index (row*8+col) of dctq.
REQ-006 SHALL have ports: hold, out, 1, registered back-pressure to the upstream coefficient source.
REQ-007 SHALL have ports: rl_run, out, 4, zero-run length preceding level.
REQ-008 SHALL have ports: rl_level, out, 10, signed level.
REQ-009 SHALL have ports: rl_eob, out, 1, token is end-of-block.
REQ-010 SHALL have ports: rl_valid, out, 1, token valid.
REQ-011 SHALL have ports: rl_ready, in, 1, sink accepts the token when rl_valid and rl_ready are both high.

Function
REQ-012 SHALL buffer coefficients in two 64x9 banks (ping-pong); a write goes to bank wsel at addr when dctq_valid=1 and hold=0.
REQ-013 SHALL mark bank wsel full on a write with addr=63, then toggle wsel.
REQ-014 SHALL register hold=1 in the cycle after a bank-filling write if the other bank is still full; hold SHALL clear the cycle after that bank is released.
REQ-015 SHALL ignore dctq_valid while hold=1.
REQ-016 SHALL scan a full bank in zigzag order, index 0..63, one index per cycle; bank reads are synchronous with 1-cycle latency.
REQ-017 SHALL use these FSM states: IDLE, SCAN, ZRL, EMIT, EOB. Transitions: IDLE->SCAN when rsel bank is full; SCAN->ZRL on a nonzero with run>15; ZRL->EMIT when run<=15; SCAN->EMIT on a nonzero; after the index-63 decision ->EOB if trailing zeros, else ->IDLE; EOB->IDLE on handshake.
REQ-018 SHALL emit the DC token (zz index 0) as run=0, level=DC, sign-extended to 10 bits, regardless of value.
REQ-019 SHALL count AC zeros in a 6-bit run counter; on a nonzero, while run>15, emit ZRL (run=15, level=0, eob=0) and subtract 16, then emit (run, level).
REQ-020 SHALL emit EOB (run=0, level=0, eob=1) only when zz index 63 is zero; when index 63 is nonzero, SHALL omit EOB.
REQ-021 SHALL hold rl_run, rl_level and rl_eob stable while rl_valid=1 and rl_ready=0, and SHALL stall the scan until the handshake.
REQ-022 SHALL release the rsel bank (clear full, toggle rsel) on the handshake of the final token.
REQ-023 With rl_ready held high, first rl_valid SHALL assert 3 cycles after the addr=63 write.
REQ-024 SHALL allow a write and a release in the same cycle; the release wins the hold evaluation, so hold stays 0.

Reset
REQ-025 reset_n low SHALL asynchronously set hold=0, rl_valid=0, rl_run=0, rl_level=0, rl_eob=0, state=IDLE, wsel=rsel=0, both banks empty, run=0 and prev_dc=0.
REQ-026 Reset mid-block SHALL discard all partial and buffered data; bank contents need not be cleared.

Configuration
REQ-027 Macro DCTQ_RLE_DCDIFF_EN: when defined, the DC token level SHALL be DC minus prev_dc (10-bit signed), and prev_dc SHALL update on the DC handshake. When undefined, level SHALL be the raw DC and no prev_dc register SHALL exist.

Structure
REQ-028 Package dctq_rle_pkg SHALL hold BLK_SIZE=64, the FSM state encoding, and the token widths (run 4, level 10).
REQ-029 Sub-module dctq_zigzag_rom SHALL be a combinational 64-entry map from zigzag index to raster addr.

Verification
REQ-030 DC=25, all AC 0 -> tokens (0,25,eob0), (0,0,eob1).
REQ-031 DC=0, addr1=-3, addr8=5, rest 0 -> tokens (0,0), (0,-3), (0,5), EOB.
REQ-032 DC=0, single 7 at zz index 20 -> tokens (0,0), ZRL(15,0), (3,7), EOB.
REQ-033 DC=0, single 4 at addr 63, rest 0 -> tokens (0,0), three ZRL, (14,4), no EOB.
REQ-034 rl_ready=0, two blocks written -> hold=1 the cycle after the second addr=63 write and third-block writes dropped; rl_ready=1 -> hold=0 the cycle after the first block's last handshake.
REQ-035 Blocks with DC 25 then 20 -> DC levels 25, -5 with DCTQ_RLE_DCDIFF_EN defined; 25, 20 without. Also pulse reset_n mid-block -> no tokens, hold=0.
